// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a 4-entry byte FIFO.
// A new frame starts on the STOP-end edge when bytes are waiting, so there are no idle gaps.
module uart_tx_fifo #(
    parameter int BAUD        = 9_600,
    parameter int INPUT_CLOCK = 16_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       full,
    output logic       busy,
    output logic       o_tx
);

    localparam int          CLOCKS_PER_BAUD = INPUT_CLOCK / BAUD;
    localparam logic [12:0] BAUD_LAST       = 13'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        push, pop, baud_done;

    assign full      = (count_q == 3'd4);
    assign busy      = (state_q != IDLE) || (count_q != 3'd0);
    assign o_tx      = tx_q;
    assign push      = write && !full;
    assign baud_done = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                pop  = (count_q != 3'd0);
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = 13'd0;
                    tx_d       = shift_q[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = 13'd0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_d = 13'd0;
                    pop        = (count_q != 3'd0);
                    state_d    = IDLE;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading the head byte is shared by the IDLE start and the back-to-back STOP restart.
        if (pop) begin
            shift_d    = mem_q[rd_ptr_q];
            bit_cnt_d  = 3'd0;
            baud_cnt_d = 13'd0;
            tx_d       = 1'b0;
            state_d    = START;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            baud_cnt_q <= 13'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers guard it, so stale entries are never read.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-timeline model of a fast (4 clocks/bit) instance
// under directed and random traffic, plus one full frame on a default-rate instance.
module tb_uart_tx_fifo;

    localparam int CPB_A = 4;
    localparam int CPB_B = 1666;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic       write_a, write_b;
    logic [7:0] data_a, data_b;
    logic       full_a, busy_a, tx_a;
    logic       full_b, busy_b, tx_b;

    uart_tx_fifo #(.BAUD(4), .INPUT_CLOCK(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .data_in(data_a), .write(write_a),
        .full(full_a), .busy(busy_a), .o_tx(tx_a)
    );

    uart_tx_fifo dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .data_in(data_b), .write(write_b),
        .full(full_b), .busy(busy_b), .o_tx(tx_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of dut_a: bytes waiting, and the byte on the line with its cycle offset into the frame.
    logic [7:0] mdl_q[$];
    bit         mdl_active = 1'b0;
    int         mdl_t      = 0;
    logic [7:0] mdl_byte   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        mdl_active = 1'b0;
        mdl_t      = 0;
    endtask

    task automatic model_step();
        int pre;
        if (!rst_a_n) begin
            model_reset();
            return;
        end
        pre = mdl_q.size();
        if (mdl_active) begin
            mdl_t++;
            if (mdl_t == 10 * CPB_A) mdl_active = 1'b0;
        end
        if (!mdl_active && pre > 0) begin
            mdl_byte   = mdl_q.pop_front();
            mdl_active = 1'b1;
            mdl_t      = 0;
        end
        if (write_a && pre < 4) mdl_q.push_back(data_a);
    endtask

    task automatic compare();
        logic exp_tx;
        exp_tx = mdl_active ? frame_bit(mdl_byte, mdl_t / CPB_A) : 1'b1;
        check("a_tx", tx_a, exp_tx);
        check("a_busy", busy_a, mdl_active || (mdl_q.size() != 0));
        check("a_full", full_a, mdl_q.size() == 4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic reset_a();
        #2 rst_a_n = 1'b0;
        #1;
        check("a_rst_tx", tx_a, 1'b1);
        check("a_rst_busy", busy_a, 1'b0);
        check("a_rst_full", full_a, 1'b0);
        model_reset();
        repeat (2) tick();
        rst_a_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       obs [40];
        logic [9:0] pat_a3;
        int         done_at;
        int         probs [6];

        rst_a_n = 1'b1; rst_b_n = 1'b1;
        write_a = 1'b0; write_b = 1'b0;
        data_a  = 8'h00; data_b = 8'h00;
        pat_a3  = 10'b1101000110;
        probs   = '{5, 30, 90, 60, 2, 50};

        #3 rst_a_n = 1'b0; rst_b_n = 1'b0;
        #1;
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_full_a", full_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_busy_b", busy_b, 1'b0);
        check("rst_full_b", full_b, 1'b0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // 0xA3 written on the first edge after reset release; data_in scrambled afterwards.
        write_a = 1'b1; data_a = 8'hA3;
        tick();
        check("a3_tx_before_start", tx_a, 1'b1);
        write_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            data_a = 8'($urandom);
            tick();
            obs[i] = tx_a;
            if (i == 39) check("a3_busy_last_cycle", busy_a, 1'b1);
        end
        check("a3_start_latency", obs[0], 1'b0);
        for (int b = 0; b < 10; b++) check($sformatf("a3_bit%0d", b), obs[b*4+2], pat_a3[b]);
        tick();
        check("a3_busy_after_frame", busy_a, 1'b0);

        // Six consecutive writes, then a write on the first STOP-end pop edge while full.
        done_at = -1;
        for (int k = 0; k < 400 && done_at < 0; k++) begin
            write_a = (k < 6) || (k == 41);
            data_a  = (k < 6) ? 8'(k + 1) : 8'hEE;
            tick();
            if (k == 4)  check("full_after_5th", full_a, 1'b1);
            if (k == 5)  check("full_after_6th_drop", full_a, 1'b1);
            if (k == 40) check("full_before_pop", full_a, 1'b1);
            if (k == 41) check("full_after_pop_drop", full_a, 1'b0);
            if (k > 5 && !busy_a) done_at = k;
        end
        write_a = 1'b0;
        check("five_frames_len", done_at, 201);

        // Reset during data bit 3 with two bytes queued.
        write_a = 1'b1;
        data_a = 8'h11; tick();
        data_a = 8'h22; tick();
        data_a = 8'h33; tick();
        write_a = 1'b0;
        repeat (16) tick();
        check("pre_rst_full_q2", full_a, 1'b0);
        reset_a();
        repeat (100) tick();
        check("post_rst_idle_tx", tx_a, 1'b1);
        check("post_rst_idle_busy", busy_a, 1'b0);

        // Random traffic at varying write densities, with one reset in the middle.
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 500; c++) begin
                write_a = ($urandom_range(0, 99) < probs[p]);
                data_a  = 8'($urandom);
                if (p == 3 && c == 250) begin
                    write_a = 1'b0;
                    reset_a();
                end
                tick();
            end
        end
        write_a = 1'b0;
        repeat (50) tick();

        // Default rate: one 0x55 frame, 1666 clocks per bit.
        data_b = 8'h55; write_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_b = 1'b0;
        check("b_tx_before_start", tx_b, 1'b1);
        for (int k = 0; k < 10 * CPB_B; k++) begin
            data_b = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("b_tx", tx_b, frame_bit(8'h55, k / CPB_B));
            if (k == CPB_B + 833)     check("b_bit0_mid", tx_b, 1'b1);
            if (k == 2 * CPB_B + 833) check("b_bit1_mid", tx_b, 1'b0);
            if (k == 10 * CPB_B - 1)  check("b_busy_last_cycle", busy_b, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        check("b_busy_after_frame", busy_b, 1'b0);
        check("b_tx_idle", tx_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD, default 9_600, serial bit rate in bits/s.
REQ-002 Parameter INPUT_CLOCK, default 16_000_000, i_clk frequency in Hz.
REQ-003 Derived CLOCKS_PER_BAUD = INPUT_CLOCK / BAUD, integer division (default 1666); legal range 2..8191, behaviour outside it undefined.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 write  input  1  push request for data_in.
REQ-008 full  output  1  FIFO holds 4 bytes; writes are ignored.
REQ-009 busy  output  1  frame in progress or FIFO non-empty.
REQ-010 o_tx  output  1  serial line, registered, idle high.

Function
REQ-011 4-entry byte FIFO; byte accepted on an edge iff write=1 and full=0 sampled at that edge.
REQ-012 write while full: byte silently dropped, FIFO unchanged, no error flag.
REQ-013 Simultaneous push and FSM pop on one edge: both take effect, occupancy unchanged.
REQ-014 full = (occupancy == 4), combinational from registered occupancy; busy = (state != IDLE) or (occupancy != 0).
REQ-015 FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: o_tx=1; on edge with occupancy != 0, pop head into shift register, clear bit counter, drive o_tx=0, enter START.
REQ-017 Latency: byte written into empty FIFO while IDLE at edge E drives o_tx low at edge E+1.
REQ-018 START: hold o_tx=0 for exactly CLOCKS_PER_BAUD cycles, then enter DATA.
REQ-019 DATA: 8 bits LSB first, each held exactly CLOCKS_PER_BAUD cycles; after bit 7 enter STOP with o_tx=1.
REQ-020 STOP: hold o_tx=1 for exactly CLOCKS_PER_BAUD cycles.
REQ-021 STOP end: if occupancy != 0, pop and enter START on the same edge (no idle gap); else enter IDLE.
REQ-022 Frame length exactly 10*CLOCKS_PER_BAUD cycles; baud counter 13 bits, wraps to 0 at CLOCKS_PER_BAUD-1.
REQ-023 data_in changes after acceptance do not affect queued or in-flight bytes.
REQ-024 FIFO pointers 2 bits, wrap 3->0; occupancy 3 bits, range 0..4.

Reset
REQ-025 i_rst_n=0 immediately forces: o_tx=1, state IDLE, occupancy 0, pointers 0, baud and bit counters 0, shift register 0x00, full=0, busy=0.
REQ-026 Reset mid-frame aborts the frame and discards FIFO contents; no partial frame resumes.
REQ-027 First write honoured on the first rising edge after i_rst_n deasserts.

Verification
REQ-028 Defaults, write 0x55 once from IDLE -> o_tx low 1666 cycles, then 1,0,1,0,1,0,1,0 at 1666 cycles each, stop high 1666; busy falls at end of stop, total 16660 cycles.
REQ-029 write held 6 consecutive cycles (0x01..0x06) from IDLE -> 0x01..0x05 accepted, full high after 5th, 0x06 dropped; five back-to-back frames, 83300 cycles, no idle gap.
REQ-030 INPUT_CLOCK=16, BAUD=4 (CPB=4), write 0xA3 -> o_tx pattern 0,1,1,0,0,0,1,0,1,1 each 4 cycles, frame 40 cycles.
REQ-031 Reset pulse during bit 3 with 2 bytes queued -> o_tx=1 immediately, busy=0, full=0; no further frames without new writes.
REQ-032 FIFO full, write asserted on the STOP-end pop edge -> full sampled 1 at that edge, byte dropped; occupancy 4->3.
REQ-033 data_in toggled every cycle after acceptance -> transmitted bits match the value sampled at the accepting edge.
